// File: rtl/input_debouncer.sv
// Double-flop synchronizer plus per-channel stability counter for the traffic-light controller inputs.
// Defining DEBOUNCE_RISE_EN adds the one-cycle rise pulse output and its flops.
module input_debouncer #(
  parameter int N_IN      = 3,
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] raw,
`ifdef DEBOUNCE_RISE_EN
  output logic [N_IN-1:0] clean,
  output logic [N_IN-1:0] rise
`else
  output logic [N_IN-1:0] clean
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N_IN-1:0]  s1;
  logic [N_IN-1:0]  s2;
  logic [CNT_W-1:0] cnt [N_IN];

  // A channel adopts the synchronized level only after DB_CYCLES straight disagreeing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      clean <= '0;
      for (int i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < N_IN; i++) begin
        if (s2[i] == clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          clean[i] <= s2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef DEBOUNCE_RISE_EN
  // Fires on exactly the edge where clean is about to go from 0 to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        rise[i] <= s2[i] & ~clean[i] & (cnt[i] == CNT_MAX);
      end
    end
  end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized and directed bench for input_debouncer with a queue-based scoreboard.
// Also builds with DEBOUNCE_RISE_EN defined, in which case the rise output is checked too.
module tb_input_debouncer;

  localparam int N_IN      = 3;
  localparam int DB_CYCLES = 16;
  localparam int CNT_W     = 5;

  typedef struct {
    logic [N_IN-1:0] clean;
    logic [N_IN-1:0] rise;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N_IN-1:0] raw = '0;
  logic [N_IN-1:0] clean;
`ifdef DEBOUNCE_RISE_EN
  logic [N_IN-1:0] rise;
`endif

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Reference model: the level each channel sees after synchronization is the raw sample
  // taken two edges earlier (zero when that edge was a reset edge). A channel's clean level
  // flips when the last DB_CYCLES synchronized samples since reset all hold the opposite value.
  logic [N_IN-1:0] sample_hist[$];
  bit              window[N_IN][$];
  logic [N_IN-1:0] m_clean = '0;

  input_debouncer #(
    .N_IN(N_IN),
    .DB_CYCLES(DB_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw(raw),
`ifdef DEBOUNCE_RISE_EN
    .clean(clean),
    .rise(rise)
`else
    .clean(clean)
`endif
  );

  always #5 clk = ~clk;

  // Predict the outputs after the coming edge, queue the prediction, then advance one cycle.
  task automatic applyStimulus(input logic rst, input logic [N_IN-1:0] value);
    logic [N_IN-1:0] synced;
    exp_t            e;
    bit              all_opp;
    reset = rst;
    raw   = value;
    synced = (sample_hist.size() >= 2) ? sample_hist[sample_hist.size()-2] : '0;
    sample_hist.push_back(rst ? '0 : value);
    if (sample_hist.size() > 2) void'(sample_hist.pop_front());
    e.rise = '0;
    if (rst) begin
      m_clean = '0;
      for (int c = 0; c < N_IN; c++) window[c].delete();
    end else begin
      for (int c = 0; c < N_IN; c++) begin
        window[c].push_back(synced[c]);
        if (window[c].size() > DB_CYCLES) void'(window[c].pop_front());
        if (window[c].size() == DB_CYCLES) begin
          all_opp = 1'b1;
          foreach (window[c][k]) if (window[c][k] == m_clean[c]) all_opp = 1'b0;
          if (all_opp) begin
            m_clean[c] = ~m_clean[c];
            e.rise[c]  = m_clean[c];
          end
        end
      end
    end
    e.clean = m_clean;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input logic rst, input logic [N_IN-1:0] value, input int n);
    for (int k = 0; k < n; k++) applyStimulus(rst, value);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (clean !== e.clean) begin
      errors++;
      $display("[TB] FAIL clean at %0t: got %b expected %b", $time, clean, e.clean);
    end
`ifdef DEBOUNCE_RISE_EN
    checks++;
    if (rise !== e.rise) begin
      errors++;
      $display("[TB] FAIL rise at %0t: got %b expected %b", $time, rise, e.rise);
    end
`endif
  endtask

  // Monitor: every edge presents a new output sample, compared against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic [N_IN-1:0] v;
    int              len;
    $display("[TB] start");
    // Reset held with all inputs high, then qualification after release.
    hold(1'b1, 3'b111, 3);
    hold(1'b0, 3'b111, 22);
    // Return to zero, then a clean step on walk.
    hold(1'b0, 3'b000, 22);
    hold(1'b0, 3'b010, 22);
    // Sensor bouncing every 3 cycles, then settling high.
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, {2'b01, 1'((k / 3) % 2)});
    hold(1'b0, 3'b011, 22);
    // Reprogram high, then a 15-cycle and a 16-cycle low glitch.
    hold(1'b0, 3'b111, 22);
    hold(1'b0, 3'b011, 15);
    hold(1'b0, 3'b111, 22);
    hold(1'b0, 3'b011, 16);
    hold(1'b0, 3'b111, 22);
    // Independence: channels 0 and 2 rise together while channel 1 bounces.
    hold(1'b0, 3'b000, 22);
    for (int k = 0; k < 24; k++) applyStimulus(1'b0, {1'b1, 1'($urandom_range(0, 1)), 1'b1});
    // Reset pulse partway through a qualifying period.
    hold(1'b0, 3'b000, 22);
    hold(1'b0, 3'b111, 10);
    hold(1'b1, 3'b111, 1);
    hold(1'b0, 3'b111, 22);
    // Random segments of held levels mixed with short bursts of per-cycle noise.
    for (int s = 0; s < 120; s++) begin
      v   = N_IN'($urandom_range(0, (1 << N_IN) - 1));
      len = $urandom_range(1, 24);
      if ($urandom_range(0, 9) == 0) hold(1'b1, v, $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < len; k++) applyStimulus(1'b0, N_IN'($urandom_range(0, (1 << N_IN) - 1)));
      end else begin
        hold(1'b0, v, len);
      end
    end
    hold(1'b0, 3'b000, 20);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
